// File: rtl/master_output_reader_if.sv
// master_output_reader_if: drain request, output-memory read port and element stream
interface master_output_reader_if #(
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    localparam int RW = $clog2(SYS_ARR_ROWS);
    localparam int CW = $clog2(SYS_ARR_COLS);
    logic start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [RW-1:0] num_rows_read;
    logic [CW-1:0] num_cols_read;
    logic done;
    logic [SYS_ARR_COLS-1:0] rd_en;
    logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] rd_addr;
    logic [SYS_ARR_COLS*DATA_WIDTH-1:0] rd_data;
    logic out_valid;
    logic out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic out_last;
    modport master (
        input start, base_addr, num_rows_read, num_cols_read, rd_data, out_ready,
        output done, rd_en, rd_addr, out_valid, out_data, out_row, out_col, out_last
    );
    modport slave (
        output start, base_addr, num_rows_read, num_cols_read, rd_data, out_ready,
        input done, rd_en, rd_addr, out_valid, out_data, out_row, out_col, out_last
    );
endinterface

// File: rtl/master_output_reader.sv
// master_output_reader: drains a submatrix from banked output memory as a row-major element stream
module master_output_reader #(
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input logic clk,
    input logic reset,
    master_output_reader_if.master bus
);
    localparam int RW = $clog2(SYS_ARR_ROWS);
    localparam int CW = $clog2(SYS_ARR_COLS);
    typedef enum logic [1:0] {IDLE, RD, LATCH, EMIT} state_t;
    state_t state;
    logic [RW-1:0] row, num_rows;
    logic [CW-1:0] col, num_cols;
    logic [ADDR_WIDTH-1:0] base;
    logic [SYS_ARR_COLS*DATA_WIDTH-1:0] row_buf;
    logic emit, last;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            row <= '0;
            col <= '0;
            base <= '0;
            num_rows <= '0;
            num_cols <= '0;
            row_buf <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    base <= bus.base_addr;
                    num_rows <= bus.num_rows_read;
                    num_cols <= bus.num_cols_read;
                    row <= '0;
                    col <= '0;
                    state <= RD;
                end
                RD: state <= LATCH;
                LATCH: begin
                    row_buf <= bus.rd_data;
                    state <= EMIT;
                end
                EMIT: if (bus.out_ready) begin
                    if (col != num_cols) col <= col + 1'b1;
                    else if (row != num_rows) begin
                        row <= row + 1'b1;
                        col <= '0;
                        state <= RD;
                    end else state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign emit = state == EMIT;
    assign last = emit && row == num_rows && col == num_cols;
    assign bus.done = state == IDLE;
    // enable banks 0..num_cols only
    assign bus.rd_en = state == RD ? {SYS_ARR_COLS{1'b1}} >> (CW'(SYS_ARR_COLS - 1) - num_cols) : '0;
    assign bus.rd_addr = {SYS_ARR_COLS{base + ADDR_WIDTH'(row)}};
    assign bus.out_valid = emit;
    assign bus.out_last = last;
    assign bus.out_data = row_buf[col*DATA_WIDTH +: DATA_WIDTH];
    assign bus.out_row = row;
    assign bus.out_col = col;
endmodule

// File: tb/tb_master_output_reader.sv
// tb_master_output_reader: directed drains with a scoreboard of expected elements and read addresses
module tb_master_output_reader;
    logic clk = 0;
    logic reset;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;

    master_output_reader_if #(16, 16, 8, 16) m();
    master_output_reader dut (.clk(clk), .reset(reset), .bus(m));

    typedef struct packed {logic [15:0] d; logic [3:0] r; logic [3:0] c; logic l;} exp_t;
    typedef struct packed {logic [15:0] mask; logic [7:0] a;} rd_t;
    exp_t exp_q[$];
    rd_t addr_q[$];
    exp_t e_mon, held;
    rd_t a_mon;
    bit stall_p = 0;

    function automatic logic [15:0] mem_val(input int c, input logic [7:0] a);
        return {a, 4'(c), 4'hA};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // memory model: data appears one cycle after its enable, poison otherwise
    always @(posedge clk)
        for (int c = 0; c < 16; c++)
            m.rd_data[c*16 +: 16] <= m.rd_en[c] ? mem_val(c, m.rd_addr[c*8 +: 8]) : 16'hDEAD;

    always @(negedge clk) begin
        if (!reset) begin
            if (m.out_valid && m.out_ready) begin
                if (exp_q.size() == 0) check("extra_elem", 1, 0);
                else begin
                    e_mon = exp_q.pop_front();
                    check("out_data", m.out_data, e_mon.d);
                    check("out_row", m.out_row, e_mon.r);
                    check("out_col", m.out_col, e_mon.c);
                    check("out_last", m.out_last, e_mon.l);
                end
            end
            if (m.rd_en != 0) begin
                if (addr_q.size() == 0) check("extra_read", 1, 0);
                else begin
                    a_mon = addr_q.pop_front();
                    check("rd_en", m.rd_en, a_mon.mask);
                    check("rd_addr", m.rd_addr, {16{a_mon.a}});
                end
            end
            if (m.out_valid) check("rd_en_in_emit", m.rd_en, 0);
            if (stall_p) begin
                check("stall_valid", m.out_valid, 1);
                check("stall_hold", {m.out_data, m.out_row, m.out_col, m.out_last}, held);
            end
        end
        stall_p = m.out_valid && !m.out_ready && !reset;
        held = {m.out_data, m.out_row, m.out_col, m.out_last};
    end

    task automatic drain(input logic [7:0] base, input int nr, input int nc,
                         input bit bp, input bit inj, input bit abort, input int exp_cyc);
        int cnt = 0;
        bit injected = 0;
        bit aborted = 0;
        logic [15:0] mask = '0;
        for (int c = 0; c <= nc; c++) mask[c] = 1'b1;
        for (int r = 0; r <= nr; r++) begin
            addr_q.push_back('{mask: mask, a: 8'(base + r)});
            for (int c = 0; c <= nc; c++)
                exp_q.push_back('{d: mem_val(c, 8'(base + r)), r: 4'(r), c: 4'(c), l: r == nr && c == nc});
        end
        m.base_addr = base;
        m.num_rows_read = 4'(nr);
        m.num_cols_read = 4'(nc);
        m.out_ready = 1;
        m.start = 1;
        @(posedge clk); #1;
        m.start = 0;
        while (!m.done && cnt < 2000) begin
            if (abort && m.out_valid && m.out_row == 4'd5) begin
                reset = 1;
                @(posedge clk); #1;
                check("abort_done", m.done, 1);
                check("abort_valid", m.out_valid, 0);
                check("abort_rd_en", m.rd_en, 0);
                check("abort_last", m.out_last, 0);
                reset = 0;
                exp_q.delete();
                addr_q.delete();
                aborted = 1;
                break;
            end
            m.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m.start = inj && !injected && m.out_valid;
            if (m.start) begin
                injected = 1;
                m.base_addr = 8'h77;
                m.num_rows_read = 4'd9;
                m.num_cols_read = 4'd9;
            end
            cnt++;
            @(posedge clk); #1;
        end
        m.start = 0;
        m.out_ready = 1;
        if (!aborted) begin
            check("no_timeout", cnt < 2000, 1);
            if (exp_cyc > 0) check("cycles", cnt, exp_cyc);
            check("elems_left", exp_q.size(), 0);
            check("reads_left", addr_q.size(), 0);
        end
    endtask

    initial begin
        reset = 1;
        m.start = 0;
        m.base_addr = 0;
        m.num_rows_read = 0;
        m.num_cols_read = 0;
        m.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", m.done, 1);
        check("rst_valid", m.out_valid, 0);
        check("rst_last", m.out_last, 0);
        check("rst_rd_en", m.rd_en, 0);
        m.start = 1;
        @(posedge clk); #1;
        check("rst_over_start", m.done, 1);
        reset = 0;
        m.start = 0;
        @(posedge clk); #1;
        check("idle_hold", m.done, 1);
        drain(8'h10, 15, 15, 0, 0, 0, 288);
        drain(8'h20, 2, 3, 0, 0, 0, 18);
        drain(8'hFE, 3, 7, 0, 0, 0, 40);
        drain(8'h33, 0, 0, 0, 0, 0, 3);
        drain(8'h40, 4, 5, 1, 0, 0, 0);
        drain(8'h50, 2, 3, 0, 1, 0, 18);
        drain(8'h60, 15, 15, 0, 0, 1, 0);
        @(posedge clk); #1;
        check("post_abort_idle", m.done, 1);
        drain(8'h70, 1, 1, 0, 0, 0, 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
